captura_jogada: RTL and testbench
=================================

Name: captura_jogada

Overview:
- Upstream input stage of the memory-game datapath.
- Sits between the raw `chaves[3:0]` switches/buttons and the game circuit's `chaves` input.
- Synchronises and debounces the key inputs, then captures each press as one stable play.
- Emits a single-cycle `jogada_feita` pulse, and requires full release before the next play is accepted.

Parameters:
- DEBOUNCE_CYCLES, 20, cycles an input must be stable (pressed or released) to be accepted; at the 1 kHz system clock this is 20 ms; legal range ≥1.
- LARGURA, 4, number of key lines.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- habilita  in  1  new presses are accepted only while high.
- chaves  in  LARGURA  raw, asynchronous key lines.
- jogada  out  LARGURA  last accepted play, held until the next capture.
- jogada_feita  out  1  one-cycle pulse when a valid play is captured.
- jogada_invalida  out  1  one-cycle pulse when a rejected pattern is captured (optional feature only).
- ocupado  out  1  high in every state except OCIOSO.
- db_estado  out  4  current state code, for the 7-segment debug display.

Behaviour:
- Synchronous active-high reset (clock and reset as stated under Ports): on the rising edge with reset=1, all of the following clear:
  - both synchroniser stages = 0;
  - counter = 0;
  - `amostra` = 0;
  - `jogada` = 0;
  - `jogada_feita` = 0, `jogada_invalida` = 0, `ocupado` = 0;
  - state = OCIOSO, `db_estado` = 0.
- Reset mid-operation aborts any capture; no pulse is emitted.
- Synchroniser: two flops; `chaves_s` = `chaves` delayed by 2 edges. All FSM decisions use `chaves_s` only.
- Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- FSM, Moore outputs, state codes in parentheses:
  - OCIOSO (0):
    - If habilita=1 and `chaves_s` != 0: load `amostra` <= `chaves_s`, counter <= 0, go to FILTRANDO.
    - Otherwise stay.
  - FILTRANDO (1):
    - If habilita=0 or `chaves_s` != `amostra`: go to OCIOSO (bounce or abort; no pulse).
    - Else if counter == DEBOUNCE_CYCLES-1: load `jogada` <= `amostra`, go to REGISTRA.
    - Else counter++.
  - REGISTRA (2): lasts exactly one cycle.
    - `jogada_feita` = 1.
    - Then counter <= 0, go to AGUARDA_SOLTAR.
  - AGUARDA_SOLTAR (3):
    - If `chaves_s` != 0: counter <= 0.
    - Else if counter == DEBOUNCE_CYCLES-1: go to OCIOSO.
    - Else counter++.
    - habilita is ignored in this state.
- Latency: with `chaves` stable and nonzero from edge 1, the FSM enters REGISTRA at edge DEBOUNCE_CYCLES+3. `jogada_feita` is high for the one cycle after that edge, with `jogada` already valid.
- Holding a key indefinitely yields exactly one pulse.
- Changing keys without releasing yields no new pulse.
- Release must be zero for DEBOUNCE_CYCLES consecutive synchronised samples.
- Simultaneous events: a pattern change on the edge where the counter reaches its limit counts as a mismatch, so the FSM returns to OCIOSO and emits no pulse.
- habilita rising while a key is already held: the press is accepted, with full debounce starting from that point.
- `ocupado` = (state != OCIOSO).

Optional Feature:
- Macro: CAPTURA_JOGADA_ONEHOT_EN.
- Defined: in REGISTRA, if `amostra` is not one-hot, the FSM pulses `jogada_invalida` and not `jogada_feita`. `jogada` is loaded with `amostra` in either case.
- Undefined: any nonzero stable pattern is accepted; `jogada_invalida` is tied to 0.

Decomposition:
- Package `jogo_pkg`:
  - state enum with the codes above;
  - LARGURA default;
  - debug code width (4).
- One natural sub-module: `sincronizador` (parameterised-width 2-flop synchroniser with synchronous reset).
- The debounce counter and FSM stay in this module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and habilita=1 unless stated.
1. Reset asserted for 10 cycles with `chaves`=0101 → all outputs 0, `db_estado`=0. After release, with keys still 0101 and habilita=1, one pulse follows at edge 7.
2. `chaves`=0010 held for 10 cycles, then 0 for 5 cycles → exactly one `jogada_feita` pulse, in the cycle after edge 7; `jogada`=0010; back to `db_estado`=0 after release debounce.
3. `chaves` toggles 0100/0000 every 2 cycles for 12 cycles, then holds 0100 → no pulse during bouncing; one pulse 7 edges after the stable hold begins.
4. `chaves`=1000 held 30 cycles, then switched to 0001 without release → a single pulse with `jogada`=1000; no second pulse until 4+ cycles of all-zero followed by a new press.
5. habilita=0 while `chaves`=0001 is pressed → no pulse, `ocupado`=0. Raise habilita with the key still held → pulse 5 edges later (DEBOUNCE_CYCLES+1).
6. CAPTURA_JOGADA_ONEHOT_EN defined, `chaves`=0110 stable → `jogada_invalida` pulses for 1 cycle, `jogada_feita` stays 0, `jogada`=0110. Without the macro, the same stimulus pulses `jogada_feita`.

Source files
------------

// File: rtl/jogo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : jogo_pkg                                                     |
// | Description : Shared types and constants for the memory-game input stage: |
// |               capture FSM state encoding, default key width, width of the  |
// |               debug state code, and the state-to-debug-code helper.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package jogo_pkg;

  // Default number of key lines.
  localparam int LARGURA_PADRAO = 4;

  // Width of the state code shown on the 7-segment debug display.
  localparam int DB_LARGURA = 4;

  // Capture FSM states; the numeric codes are what the debug display shows.
  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    FILTRANDO      = 2'd1,
    REGISTRA       = 2'd2,
    AGUARDA_SOLTAR = 2'd3
  } estado_t;

  // Zero-extends a state to the debug display code width.
  function automatic logic [DB_LARGURA-1:0] codigo_debug(input estado_t e);
    return DB_LARGURA'(e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/captura_jogada_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : captura_jogada_if                                            |
// | Description : Key-capture bus between the raw key inputs, the capture     |
// |               stage and the game circuit.                                  |
// |   habilita        : capture enable (towards capture stage)                 |
// |   chaves          : raw asynchronous key lines (towards capture stage)     |
// |   jogada          : last accepted play (from capture stage)                |
// |   jogada_feita    : one-cycle valid-play pulse                             |
// |   jogada_invalida : one-cycle rejected-play pulse                          |
// |   ocupado         : capture stage is not idle                              |
// |   db_estado       : current state code for the debug display               |
// |   Modports: master (drives keys/enable), slave (the capture stage).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface captura_jogada_if
  import jogo_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  logic                  habilita;
  logic [LARGURA-1:0]    chaves;
  logic [LARGURA-1:0]    jogada;
  logic                  jogada_feita;
  logic                  jogada_invalida;
  logic                  ocupado;
  logic [DB_LARGURA-1:0] db_estado;

  modport master (
    output habilita,
    output chaves,
    input  jogada,
    input  jogada_feita,
    input  jogada_invalida,
    input  ocupado,
    input  db_estado
  );

  modport slave (
    input  habilita,
    input  chaves,
    output jogada,
    output jogada_feita,
    output jogada_invalida,
    output ocupado,
    output db_estado
  );

endinterface
`default_nettype wire

// File: rtl/captura_jogada_sincronizador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sincronizador                                                |
// | Description : Two-flop synchroniser for a bus of independent asynchronous |
// |               lines. Output is the input delayed by two clock edges.       |
// |   clock : system clock, rising edge                                        |
// |   reset : synchronous, active-high; clears both stages                     |
// |   d     : asynchronous input lines                                         |
// |   q     : synchronised lines                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sincronizador #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta_q, meta_d;
  logic [LARGURA-1:0] sinc_q, sinc_d;

  always_comb begin
    meta_d = d;
    sinc_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign q = sinc_q;

endmodule
`default_nettype wire

// File: rtl/captura_jogada.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : captura_jogada                                               |
// | Description : Input stage of the memory-game datapath. Synchronises and   |
// |               debounces the key lines, captures each press as one stable   |
// |               play with a single-cycle pulse, and requires a debounced     |
// |               full release before the next play is accepted.               |
// |   clock : system clock, rising edge                                        |
// |   reset : synchronous, active-high                                         |
// |   bus   : captura_jogada_if.slave (habilita, chaves in; jogada,           |
// |           jogada_feita, jogada_invalida, ocupado, db_estado out)           |
// |   Optional macro CAPTURA_JOGADA_ONEHOT_EN: non-one-hot patterns pulse     |
// |   jogada_invalida instead of jogada_feita.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module captura_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LARGURA         = LARGURA_PADRAO
) (
  input  logic            clock,
  input  logic            reset,
  captura_jogada_if.slave bus
);

  localparam int                CONT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CONT_W-1:0] CONT_LIMITE = CONT_W'(DEBOUNCE_CYCLES - 1);

  logic [LARGURA-1:0] chaves_s;

  estado_t            estado_q,   estado_d;
  logic [CONT_W-1:0]  contador_q, contador_d;
  logic [LARGURA-1:0] amostra_q,  amostra_d;
  logic [LARGURA-1:0] jogada_q,   jogada_d;
  logic               amostra_valida;

  sincronizador #(
    .LARGURA (LARGURA)
  ) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .d     (bus.chaves),
    .q     (chaves_s)
  );

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    amostra_d  = amostra_q;
    jogada_d   = jogada_q;

    case (estado_q)
      OCIOSO: begin
        if (bus.habilita && (chaves_s != '0)) begin
          amostra_d  = chaves_s;
          contador_d = '0;
          estado_d   = FILTRANDO;
        end
      end

      FILTRANDO: begin
        // Mismatch takes priority over reaching the limit, so a pattern
        // change on the final edge is treated as a bounce.
        if (!bus.habilita || (chaves_s != amostra_q)) begin
          estado_d = OCIOSO;
        end else if (contador_q == CONT_LIMITE) begin
          jogada_d = amostra_q;
          estado_d = REGISTRA;
        end else begin
          contador_d = contador_q + 1'b1;
        end
      end

      REGISTRA: begin
        contador_d = '0;
        estado_d   = AGUARDA_SOLTAR;
      end

      AGUARDA_SOLTAR: begin
        // Any nonzero sample restarts the release window; habilita is
        // deliberately not consulted here.
        if (chaves_s != '0) begin
          contador_d = '0;
        end else if (contador_q == CONT_LIMITE) begin
          estado_d = OCIOSO;
        end else begin
          contador_d = contador_q + 1'b1;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      amostra_q  <= '0;
      jogada_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      amostra_q  <= amostra_d;
      jogada_q   <= jogada_d;
    end
  end

`ifdef CAPTURA_JOGADA_ONEHOT_EN
  assign amostra_valida      = $onehot(amostra_q);
  assign bus.jogada_invalida = (estado_q == REGISTRA) && !amostra_valida;
`else
  assign amostra_valida      = 1'b1;
  assign bus.jogada_invalida = 1'b0;
`endif

  assign bus.jogada_feita = (estado_q == REGISTRA) && amostra_valida;
  assign bus.jogada       = jogada_q;
  assign bus.ocupado      = (estado_q != OCIOSO);
  assign bus.db_estado    = codigo_debug(estado_q);

endmodule
`default_nettype wire

// File: tb/tb_captura_jogada.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_captura_jogada                                            |
// | Description : Self-checking bench for captura_jogada with                  |
// |               DEBOUNCE_CYCLES=4. Hand-written reset sequences, then a      |
// |               table of key segments; each segment's expectation (pulse     |
// |               count, pulse edge, jogada, state) is queued when driven and  |
// |               popped and compared when the segment ends.                   |
// |   Honours CAPTURA_JOGADA_ONEHOT_EN for the non-one-hot patterns.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_captura_jogada;
  import jogo_pkg::*;

  localparam int D = 4;
`ifdef CAPTURA_JOGADA_ONEHOT_EN
  localparam int OH = 1;
`else
  localparam int OH = 0;
`endif

  typedef struct packed {
    logic [3:0] chaves;
    logic       habilita;
    int         ciclos;
    int         pulsos;     // expected jogada_feita pulses in segment
    int         invalidos;  // expected jogada_invalida pulses in segment
    int         borda;      // edge (from segment start) the pulse follows
    logic [3:0] jogada;
    logic [3:0] estado;
  } vetor_t;

  logic clock = 1'b0;
  logic reset;

  captura_jogada_if #(.LARGURA(4)) bus ();

  captura_jogada #(
    .DEBOUNCE_CYCLES (D),
    .LARGURA         (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int bordas       = 0;
  int pulsos       = 0;
  int invalidos    = 0;
  int ultima_borda = -1;

  always @(posedge clock) bordas <= bordas + 1;

  always @(negedge clock) begin
    if (bus.jogada_feita === 1'b1) begin
      pulsos       <= pulsos + 1;
      ultima_borda <= bordas;
    end
    if (bus.jogada_invalida === 1'b1) begin
      invalidos    <= invalidos + 1;
      ultima_borda <= bordas;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nome, input int atual, input int esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  function automatic vetor_t vet(input logic [3:0] ch, input logic hab, input int cic,
                                 input int pul, input int inv, input int bor,
                                 input logic [3:0] jog, input logic [3:0] est);
    vetor_t v;
    v.chaves = ch; v.habilita = hab; v.ciclos = cic; v.pulsos = pul;
    v.invalidos = inv; v.borda = bor; v.jogada = jog; v.estado = est;
    return v;
  endfunction

  vetor_t tabela[$];
  vetor_t esperado[$];

  task automatic aplica(input vetor_t v, input int idx);
    vetor_t e;
    int base_b, base_p, base_i;
    bus.chaves   = v.chaves;
    bus.habilita = v.habilita;
    esperado.push_back(v);
    base_b = bordas;
    base_p = pulsos;
    base_i = invalidos;
    repeat (v.ciclos) @(posedge clock);
    #1;
    e = esperado.pop_front();
    check($sformatf("v%0d_pulsos", idx), pulsos - base_p, e.pulsos);
    check($sformatf("v%0d_invalidos", idx), invalidos - base_i, e.invalidos);
    if (e.pulsos + e.invalidos > 0)
      check($sformatf("v%0d_borda", idx), ultima_borda - base_b, e.borda);
    check($sformatf("v%0d_jogada", idx), int'(bus.jogada), int'(e.jogada));
    check($sformatf("v%0d_estado", idx), int'(bus.db_estado), int'(e.estado));
    check($sformatf("v%0d_ocupado", idx), int'(bus.ocupado), int'(e.estado != 4'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_b, base_p, base_i;
    int visto;

    // ---- Reset held with a key pressed: everything stays cleared ----
    reset        = 1'b1;
    bus.habilita = 1'b1;
    bus.chaves   = 4'b0101;
    repeat (10) @(posedge clock);
    #1;
    check("reset_jogada", int'(bus.jogada), 0);
    check("reset_feita", int'(bus.jogada_feita), 0);
    check("reset_invalida", int'(bus.jogada_invalida), 0);
    check("reset_ocupado", int'(bus.ocupado), 0);
    check("reset_estado", int'(bus.db_estado), 0);
    check("reset_sem_pulso", pulsos + invalidos, 0);

    // Release reset with the key still held: capture follows edge 7.
    reset  = 1'b0;
    base_b = bordas;
    visto  = 0;
    for (int i = 0; i < 20 && visto == 0; i++) begin
      @(posedge clock);
      #1;
      if (bus.jogada_feita === 1'b1 || bus.jogada_invalida === 1'b1) visto = 1;
    end
    check("posreset_pulso_visto", visto, 1);
    check("posreset_borda", bordas - base_b, 7);
    check("posreset_feita", int'(bus.jogada_feita), 1 - OH);
    check("posreset_invalida", int'(bus.jogada_invalida), OH);
    check("posreset_jogada", int'(bus.jogada), 5);
    @(posedge clock);
    #1;
    check("posreset_pulso_unico", int'(bus.jogada_feita) + int'(bus.jogada_invalida), 0);
    check("posreset_aguarda", int'(bus.db_estado), 3);
    bus.chaves = 4'b0000;
    repeat (8) @(posedge clock);
    #1;
    check("posreset_solto", int'(bus.db_estado), 0);

    // ---- Reset in the middle of a debounce aborts without a pulse ----
    base_p = pulsos;
    base_i = invalidos;
    bus.chaves = 4'b0100;
    repeat (5) @(posedge clock);
    #1;
    check("abort_filtrando", int'(bus.db_estado), 1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_estado", int'(bus.db_estado), 0);
    check("abort_jogada", int'(bus.jogada), 0);
    reset      = 1'b0;
    bus.chaves = 4'b0000;
    repeat (6) @(posedge clock);
    #1;
    check("abort_sem_pulso", (pulsos - base_p) + (invalidos - base_i), 0);
    check("abort_ocioso", int'(bus.db_estado), 0);

    // ---- Segment table ----
    // single press then exact-length release
    tabela.push_back(vet(4'b0010, 1'b1, 10, 1, 0, 7, 4'b0010, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  6, 0, 0, 0, 4'b0010, 4'd0));
    // bouncing every 2 cycles, then a stable hold
    for (int k = 0; k < 3; k++) begin
      tabela.push_back(vet(4'b0100, 1'b1, 2, 0, 0, 0, 4'b0010, 4'd0));
      tabela.push_back(vet(4'b0000, 1'b1, 2, 0, 0, 0, 4'b0010, 4'd1));
    end
    tabela.push_back(vet(4'b0100, 1'b1, 10, 1, 0, 7, 4'b0100, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  8, 0, 0, 0, 4'b0100, 4'd0));
    // long hold, key change without release, too-short release
    tabela.push_back(vet(4'b1000, 1'b1, 30, 1, 0, 7, 4'b1000, 4'd3));
    tabela.push_back(vet(4'b0001, 1'b1, 10, 0, 0, 0, 4'b1000, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  3, 0, 0, 0, 4'b1000, 4'd3));
    tabela.push_back(vet(4'b0001, 1'b1, 10, 0, 0, 0, 4'b1000, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  6, 0, 0, 0, 4'b1000, 4'd0));
    // habilita low while pressed, then raised with the key held
    tabela.push_back(vet(4'b0001, 1'b0, 10, 0, 0, 0, 4'b1000, 4'd0));
    tabela.push_back(vet(4'b0001, 1'b1, 10, 1, 0, 5, 4'b0001, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  6, 0, 0, 0, 4'b0001, 4'd0));
    // pattern change seen on the same edge the counter hits its limit
    tabela.push_back(vet(4'b0010, 1'b1,  4, 0, 0, 0, 4'b0001, 4'd1));
    tabela.push_back(vet(4'b1000, 1'b1, 10, 1, 0, 8, 4'b1000, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  8, 0, 0, 0, 4'b1000, 4'd0));
    // non-one-hot pattern
    tabela.push_back(vet(4'b0110, 1'b1, 10, 1 - OH, OH, 7, 4'b0110, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  6, 0, 0, 0, 4'b0110, 4'd0));
    // habilita ignored while waiting for release
    tabela.push_back(vet(4'b0100, 1'b1, 10, 1, 0, 7, 4'b0100, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b0,  6, 0, 0, 0, 4'b0100, 4'd0));
    // habilita dropped during debounce aborts; re-raised restarts debounce
    tabela.push_back(vet(4'b0010, 1'b1,  4, 0, 0, 0, 4'b0100, 4'd1));
    tabela.push_back(vet(4'b0010, 1'b0,  3, 0, 0, 0, 4'b0100, 4'd0));
    tabela.push_back(vet(4'b0010, 1'b1, 10, 1, 0, 5, 4'b0010, 4'd3));
    tabela.push_back(vet(4'b0000, 1'b1,  6, 0, 0, 0, 4'b0010, 4'd0));

    for (int i = 0; i < tabela.size(); i++) aplica(tabela[i], i);

    check("scoreboard_vazio", esperado.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
